// File: rtl/tick_pkg.sv
// Shared types and BCD helpers for the tick countdown consumer.
package tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic [3:0] clamp_nibble(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/tick_countdown_if.sv
// Strobe/status bundle between the tick generator side and the countdown consumer.
interface tick_countdown_if #(parameter int DIGITS = 2);

    logic                  tick_in;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  go;
    logic                  hold;
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  done;
    logic                  sync_start;

    modport master (
        output tick_in, load, load_val, go, hold,
        input  count, running, done, sync_start
    );

    modport slave (
        input  tick_in, load, load_val, go, hold,
        output count, running, done, sync_start
    );

endinterface

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a borrow-chained decrementer; purely combinational.
module bcd_digit_dec
    import tick_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == BCD_ZERO) begin
                next_digit = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/tick_countdown.sv
// BCD countdown driven by the 1 Hz tick; requests a tick-generator resync on start/resume.
// Optional: TICK_COUNTDOWN_AUTO_RELOAD_EN reloads the preset on expiry and pulses done.
module tick_countdown
    import tick_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    tick_countdown_if.slave  bus
);

    localparam int W = 4 * DIGITS;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   preset_q, preset_d;
    logic           running_q, done_q, sync_q;
    logic           running_d, done_d, sync_d;
    logic           expire_pulse;

    logic [W-1:0]   dec_count;
    logic [W-1:0]   clamped;
    logic [DIGITS:0] borrow;
    logic           reached_zero;

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dec
        bcd_digit_dec u_digit (
            .digit      (count_q[4*i +: 4]),
            .borrow_in  (borrow[i]),
            .next_digit (dec_count[4*i +: 4]),
            .borrow_out (borrow[i+1])
        );
    end

    // A borrow out of the top digit means we decremented from zero; treat it as expiry too.
    assign reached_zero = (dec_count == '0) || borrow[DIGITS];

    always_comb begin
        clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            clamped[4*i +: 4] = clamp_nibble(bus.load_val[4*i +: 4]);
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        preset_d     = preset_q;
        sync_d       = 1'b0;
        expire_pulse = 1'b0;

        if (bus.load) begin
            count_d  = clamped;
            preset_d = clamped;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.go && (count_q != '0)) begin
                        state_d = RUN;
                        sync_d  = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.tick_in) begin
                        if (reached_zero) begin
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
                            if (preset_q != '0) begin
                                count_d      = preset_q;
                                expire_pulse = 1'b1;
                                if (bus.hold) begin
                                    state_d = PAUSE;
                                end
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
`else
                            count_d = '0;
                            state_d = DONE;
`endif
                        end else begin
                            count_d = dec_count;
                            if (bus.hold) begin
                                state_d = PAUSE;
                            end
                        end
                    end else if (bus.hold) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (bus.go) begin
                        state_d = RUN;
                        sync_d  = 1'b1;
                    end
                end
                DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == RUN);
        done_d    = (state_d == DONE) || expire_pulse;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            preset_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            preset_q  <= preset_d;
            running_q <= running_d;
            done_q    <= done_d;
            sync_q    <= sync_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.sync_start = sync_q;

endmodule

// File: tb/tb_tick_countdown.sv
// Directed plus randomized bench for tick_countdown against a decimal-arithmetic reference model.
module tb_tick_countdown;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;
`ifdef TICK_COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #4 clk = ~clk;

    tick_countdown_if #(.DIGITS(DIGITS)) bus_if ();

    tick_countdown #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: count kept as a plain integer, activity as independent flags.
    int m_cnt, m_preset;
    bit m_run, m_pause, m_fin, m_done, m_sync;

    function automatic int clamp_value(input logic [W-1:0] lv);
        int v, scale, d;
        v = 0;
        scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v += d * scale;
            scale *= 10;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic modelReset();
        m_cnt = 0; m_preset = 0;
        m_run = 0; m_pause = 0; m_fin = 0; m_done = 0; m_sync = 0;
    endtask

    task automatic modelStep(input bit t, input bit l, input logic [W-1:0] lv, input bit g, input bit h);
        bit pulse;
        pulse  = 0;
        m_sync = 0;
        if (l) begin
            m_cnt = clamp_value(lv);
            m_preset = m_cnt;
            m_run = 0; m_pause = 0; m_fin = 0;
        end else if (m_fin) begin
            m_cnt = 0;
        end else if (m_run) begin
            if (t) begin
                m_cnt = m_cnt - 1;
                if (m_cnt <= 0) begin
                    if (AUTO && m_preset != 0) begin
                        m_cnt = m_preset;
                        pulse = 1;
                        if (h) begin m_run = 0; m_pause = 1; end
                    end else begin
                        m_cnt = 0; m_run = 0; m_fin = 1;
                    end
                end else if (h) begin
                    m_run = 0; m_pause = 1;
                end
            end else if (h) begin
                m_run = 0; m_pause = 1;
            end
        end else if (m_pause) begin
            if (g) begin m_pause = 0; m_run = 1; m_sync = 1; end
        end else begin
            if (g && m_cnt != 0) begin m_run = 1; m_sync = 1; end
        end
        m_done = m_fin || pulse;
    endtask

    task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".count"},      bus_if.count,             to_bcd(m_cnt));
        checkValue({tag, ".running"},    W'(bus_if.running),       W'(m_run));
        checkValue({tag, ".done"},       W'(bus_if.done),          W'(m_done));
        checkValue({tag, ".sync_start"}, W'(bus_if.sync_start),    W'(m_sync));
    endtask

    // Drive strobes for one clock, then compare against the model just after the edge.
    task automatic applyStimulus(input string tag, input bit t, input bit l, input logic [W-1:0] lv,
                                 input bit g, input bit h);
        bus_if.tick_in  = t;
        bus_if.load     = l;
        bus_if.load_val = lv;
        bus_if.go       = g;
        bus_if.hold     = h;
        @(posedge clk);
        #1;
        modelStep(t, l, lv, g, h);
        bus_if.tick_in = 0; bus_if.load = 0; bus_if.go = 0; bus_if.hold = 0;
        checkOutput(tag);
    endtask

    initial begin
        int r;
        bit t, l, g, h;
        logic [W-1:0] lv;

        bus_if.tick_in = 0; bus_if.load = 0; bus_if.load_val = '0;
        bus_if.go = 0; bus_if.hold = 0;
        rst = 1'b1;
        modelReset();
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset");
        rst = 1'b0;

        applyStimulus("load3C", 0, 1, 8'h3C, 0, 0);
        checkValue("clamp", bus_if.count, 8'h39);

        applyStimulus("load03", 0, 1, 8'h03, 0, 0);
        applyStimulus("go03", 0, 0, '0, 1, 0);
        checkValue("go_sync", W'(bus_if.sync_start), W'(1));
        applyStimulus("run_idle", 0, 0, '0, 0, 0);
        applyStimulus("go_again", 0, 0, '0, 1, 0);
        applyStimulus("tick1", 1, 0, '0, 0, 0);
        applyStimulus("tick2", 1, 0, '0, 0, 0);
        applyStimulus("tick3", 1, 0, '0, 0, 0);
        checkValue("expire_done", W'(bus_if.done), W'(1));
        applyStimulus("tick_done", 1, 0, '0, 0, 0);
        applyStimulus("go_done", 0, 0, '0, 1, 0);

        applyStimulus("load10", 0, 1, 8'h10, 0, 0);
        applyStimulus("go10", 0, 0, '0, 1, 0);
        applyStimulus("borrow", 1, 0, '0, 0, 0);
        checkValue("borrow_val", bus_if.count, 8'h09);
        applyStimulus("load00", 0, 1, 8'h00, 0, 0);
        applyStimulus("go00", 0, 0, '0, 1, 0);

        applyStimulus("load05", 0, 1, 8'h05, 0, 0);
        applyStimulus("go05", 0, 0, '0, 1, 0);
        applyStimulus("tick05", 1, 0, '0, 0, 0);
        applyStimulus("tick_hold", 1, 0, '0, 0, 1);
        checkValue("pause_val", bus_if.count, 8'h03);
        for (int i = 0; i < 5; i++) applyStimulus("pause_tick", 1, 0, '0, 0, 0);
        applyStimulus("pause_hold", 0, 0, '0, 0, 1);
        applyStimulus("resume", 0, 0, '0, 1, 0);
        applyStimulus("resume_tick", 1, 0, '0, 0, 0);
        checkValue("resume_val", bus_if.count, 8'h02);
        applyStimulus("run_hold", 0, 0, '0, 0, 1);

        applyStimulus("load07", 0, 1, 8'h07, 0, 0);
        applyStimulus("go07", 0, 0, '0, 1, 0);
        applyStimulus("load_tick", 1, 1, 8'h20, 0, 0);
        checkValue("prio_val", bus_if.count, 8'h20);

        applyStimulus("load02", 0, 1, 8'h02, 0, 0);
        applyStimulus("go02", 0, 0, '0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus("auto_tick", 1, 0, '0, 0, 0);

        applyStimulus("load09", 0, 1, 8'h09, 0, 0);
        applyStimulus("go09", 0, 0, '0, 1, 0);
        applyStimulus("tick09", 1, 0, '0, 0, 0);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus("post_reset", 0, 0, '0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            t = 0; l = 0; g = 0; h = 0; lv = '0;
            if (r < 6) begin
                l = 1;
                t = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) lv = W'($urandom);
                else lv = {4'h0, 4'($urandom_range(1, 9))};
            end else if (r < 40) begin
                t = 1;
                h = ($urandom_range(0, 9) == 0);
            end else if (r < 48) begin
                h = 1;
            end else if (r < 60) begin
                g = 1;
            end
            applyStimulus("random", t, l, lv, g, h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tick_countdown.md
Name: tick_countdown

Overview:
- Consumer end of the 1 Hz tick interface: receives the single-cycle `tick_in` pulse from the board tick generator.
- Decrements a loaded BCD countdown value once per tick.
- Drives the count to the display path and asserts `done` at zero.
- Issues a one-cycle `sync_start` pulse back to the tick generator's start input whenever counting begins or resumes, so the first tick is phase-aligned to the command.

Parameters:
- DIGITS, 2, number of BCD digits in the countdown (1..4).

Ports:
- clk  input  1  system clock (125 MHz)
- rst  input  1  reset; asynchronous, active-high
- tick_in  input  1  single-cycle tick pulse from the tick generator
- load  input  1  single-cycle strobe: capture load_val
- load_val  input  4*DIGITS  BCD preset, most significant digit in the top nibble
- go  input  1  single-cycle strobe: start or resume counting
- hold  input  1  single-cycle strobe: pause counting
- count  output  4*DIGITS  current BCD value, registered
- running  output  1  high while in RUN
- done  output  1  countdown reached zero
- sync_start  output  1  single-cycle resync request to the tick generator

Behaviour:
- Reset (async, rst=1), all registers clear immediately:
  - count=0, preset=0, running=0, done=0, sync_start=0
  - state=IDLE
- State machine: IDLE, RUN, PAUSE, DONE. All outputs are registered; one cycle latency from any strobe or tick to the outputs.
- Priority is fixed, highest first: load > tick_in > hold > go.
- load, in any state:
  - preset and count take load_val, with each nibble >9 clamped to 9.
  - state goes to IDLE; done, running, sync_start go to 0.
  - A tick_in in the same cycle is discarded.
- IDLE:
  - go with count≠0: go to RUN, running=1, sync_start=1 for exactly one cycle.
  - go with count=0: ignored; stay in IDLE.
  - tick_in and hold: ignored.
- RUN, on tick_in:
  - count decrements by 1 in BCD; a digit at 0 borrows, wraps to 9 and decrements the next digit.
  - If the result is 0: go to DONE, running=0, done=1.
  - tick_in together with hold: the decrement is applied, then the state goes to PAUSE (or DONE if the result is 0).
- RUN, on hold without tick_in: go to PAUSE, running=0.
- RUN, on go: ignored; no second sync_start.
- PAUSE:
  - count is frozen; tick_in is ignored.
  - go: back to RUN, running=1, sync_start=1 for one cycle.
  - hold: ignored.
- DONE:
  - done stays high (level); count=0; tick_in, go and hold are ignored.
  - Only load or rst leaves DONE.
- sync_start never asserts two cycles in a row.
- Reset mid-count: immediate clear; no pulse is emitted on reset release.

Optional Feature:
- Macro: TICK_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On reaching 0 in RUN with preset≠0: count reloads from preset in the same cycle and the state stays in RUN.
  - done pulses high for one cycle per expiry instead of latching; DONE state is unreachable.
  - With preset=0, behaviour is identical to the undefined case.
- Undefined: behaviour exactly as above; the preset register still exists so load_val clamping is unchanged.

Decomposition:
- Shared package tick_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE), 2-bit
  - BCD constants: BCD_MAX=4'd9, BCD_ZERO=4'd0
  - a nibble clamp function
- One natural sub-module: bcd_digit_dec.
  - Inputs: 4-bit digit, borrow_in. Outputs: next digit, borrow_out.
  - Combinational; instantiated DIGITS times in a borrow chain.

Test Plan (DIGITS=2):
- Reset/load: rst pulse mid-count → all outputs 0 the same cycle; load with load_val=8'h3C → count=8'h39 (low nibble clamped).
- Basic run: load 8'h03, go → sync_start high exactly 1 cycle, running=1; three tick_in pulses → count 02, 01, 00; done=1, running=0; further ticks leave count at 00.
- Borrow: load 8'h10, go, one tick_in → count=8'h09; load 8'h00 then go → stays IDLE, no sync_start.
- Pause/resume: load 8'h05, go, one tick → 04; hold with a simultaneous tick → count 03, state PAUSE; 5 ticks → count stays 03; go → sync_start 1 cycle, next tick → 02.
- Priority: in RUN at 8'h07, assert load (8'h20) and tick_in in the same cycle → count=8'h20, IDLE, tick discarded; in DONE, go → no effect, done stays 1.
- AUTO_RELOAD (macro defined): load 8'h02, go, 4 ticks → count 01, 02, 01, 02 with done high for one cycle after ticks 2 and 4; running stays 1 throughout.
